// File: rtl/vita49_trig_pkg.sv
// Shared types and constants for the VITA-49 trigger scheduler.
// ts_t holds a full {tsi, tsf} timestamp.
package vita49_trig_pkg;

    typedef logic [95:0] ts_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PULSE
    } state_t;

    localparam logic LATE_FIRE = 1'b0;
    localparam logic LATE_DROP = 1'b1;

    // A programmed width of zero still produces a one-cycle pulse.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/vita49_trig_fifo.sv
// Synchronous FIFO of trigger timestamps with a registered head.
// flush is a synchronous clear.
module vita49_trig_fifo
    import vita49_trig_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [95:0]              wr_data,
    input  logic                     pop,
    output logic [95:0]              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    ts_t              mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_next = rd_ptr + 1'b1;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The head register takes the incoming word when the queue is (or becomes) empty,
    // otherwise the entry behind the one being popped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_push && (count == {{PTR_W{1'b0}}, do_pop})) begin
                head <= wr_data;
            end else if (do_pop) begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/vita49_trig_sched.sv
// Timestamp-ordered trigger scheduler: compares the oldest queued time against
// the running {tsi, tsf} counters and emits a programmable-width trig pulse.
module vita49_trig_sched
    import vita49_trig_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     AXIS_ACLK,
    input  logic                     AXIS_ARESET,
    input  logic [31:0]              tsi,
    input  logic [63:0]              tsf,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_tsi,
    input  logic [63:0]              s_tsf,
    input  logic                     enable,
    input  logic                     late_drop,
    input  logic                     flush,
    input  logic [7:0]               pulse_len,
    output logic                     trig,
    output logic                     fire,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         late_cnt,
    output logic                     busy
);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       pulse_cnt_q;
    logic             fire_q;
    logic [CNT_W-1:0] late_cnt_q;

    ts_t  now;
    ts_t  head;
    logic full;
    logic empty;
    logic push_ok;
    logic head_due;
    logic head_late;
    logic pop;
    logic start_pulse;
    logic drop;

    assign now       = {tsi, tsf};
    assign s_ready   = !full && !flush && !AXIS_ARESET;
    assign push_ok   = s_valid && s_ready;
    assign head_due  = !empty && (head <= now);
    assign head_late = !empty && (head < now);

    vita49_trig_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (AXIS_ACLK),
        .rst     (AXIS_ARESET),
        .clr     (flush),
        .push    (push_ok),
        .wr_data ({s_tsi, s_tsf}),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // IDLE also looks at a same-cycle push so a new entry is compared one cycle after it lands.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        start_pulse = 1'b0;
        drop        = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && (!empty || push_ok)) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (head_due) begin
                        pop = 1'b1;
                        if (head_late && (late_drop == LATE_DROP)) begin
                            drop = 1'b1;
                        end else begin
                            start_pulse = 1'b1;
                            state_d     = PULSE;
                        end
                    end
                end
                PULSE: begin
                    if (pulse_cnt_q == 8'd0) begin
                        state_d = (enable && !empty) ? ARMED : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q     <= IDLE;
            pulse_cnt_q <= 8'd0;
            fire_q      <= 1'b0;
            late_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fire_q  <= start_pulse;
            if (start_pulse) begin
                pulse_cnt_q <= eff_len(pulse_len) - 8'd1;
            end else if ((state_q == PULSE) && (pulse_cnt_q != 8'd0)) begin
                pulse_cnt_q <= pulse_cnt_q - 8'd1;
            end
            if (drop && (late_cnt_q != '1)) begin
                late_cnt_q <= late_cnt_q + 1'b1;
            end
        end
    end

    assign trig     = (state_q == PULSE);
    assign fire     = fire_q;
    assign busy     = (state_q != IDLE);
    assign late_cnt = late_cnt_q;

endmodule

// File: tb/tb_vita49_trig_sched.sv
// Randomized scoreboard bench for vita49_trig_sched against a queue-based
// reference model of the scheduling rules.
module tb_vita49_trig_sched;

    localparam int DEPTH    = 8;
    localparam int CNT_W    = 3;
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int LATE_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_PULSE  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      tsi;
    logic [63:0]      tsf;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_tsi;
    logic [63:0]      s_tsf;
    logic             enable;
    logic             late_drop;
    logic             flush;
    logic [7:0]       pulse_len;
    logic             trig;
    logic             fire;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] late_cnt;
    logic             busy;

    int          checks  = 0;
    int          errors  = 0;
    int          cycle   = 0;
    bit          started = 0;
    logic [95:0] mq[$];
    int          m_st       = M_IDLE;
    int          m_left     = 0;
    int          m_late     = 0;
    bit          m_push_acc = 0;
    int          exp_fire[$];
    logic [95:0] now_ts;
    int          step = 1;

    vita49_trig_sched #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESET (rst),
        .tsi         (tsi),
        .tsf         (tsf),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_tsi       (s_tsi),
        .s_tsf       (s_tsf),
        .enable      (enable),
        .late_drop   (late_drop),
        .flush       (flush),
        .pulse_len   (pulse_len),
        .trig        (trig),
        .fire        (fire),
        .level       (level),
        .late_cnt    (late_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cycle);
        end
    endtask

    // Reference model: a FIFO of times, an armed flag and a remaining-pulse count.
    always @(posedge clk) begin : model
        logic [95:0] hd;
        logic [95:0] nowv;
        int          sz;
        bit          push;
        cycle++;
        started    = 1;
        m_push_acc = 0;
        if (rst) begin
            mq.delete();
            m_st   = M_IDLE;
            m_left = 0;
            m_late = 0;
        end else begin
            sz         = mq.size();
            nowv       = {tsi, tsf};
            push       = s_valid && (sz < DEPTH) && !flush;
            m_push_acc = push;
            if (flush) begin
                mq.delete();
                m_st = M_IDLE;
            end else begin
                case (m_st)
                    M_IDLE: begin
                        if (enable && (sz > 0 || push)) m_st = M_ARMED;
                    end
                    M_ARMED: begin
                        if (!enable) begin
                            m_st = M_IDLE;
                        end else if (sz > 0 && mq[0] <= nowv) begin
                            hd = mq.pop_front();
                            if (hd < nowv && late_drop) begin
                                if (m_late < LATE_MAX) m_late++;
                            end else begin
                                m_st   = M_PULSE;
                                m_left = (pulse_len == 8'd0) ? 1 : int'(pulse_len);
                                exp_fire.push_back(cycle);
                            end
                        end
                    end
                    default: begin
                        m_left--;
                        if (m_left == 0) m_st = (enable && sz > 0) ? M_ARMED : M_IDLE;
                    end
                endcase
                if (push) mq.push_back({s_tsi, s_tsf});
            end
        end
    end

    // Monitor: level-type outputs every cycle, fire strobes against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("trig", 96'(trig), 96'(m_st == M_PULSE));
            checkOutput("busy", 96'(busy), 96'(m_st != M_IDLE));
            checkOutput("level", 96'(level), 96'(mq.size()));
            checkOutput("late_cnt", 96'(late_cnt), 96'(m_late));
            checkOutput("s_ready", 96'(s_ready), 96'(!rst && (mq.size() < DEPTH) && !flush));
            if (fire === 1'b1) begin
                if (exp_fire.size() == 0) checkOutput("fire_unexpected", 96'(fire), 96'(0));
                else checkOutput("fire_cycle", 96'(cycle), 96'(exp_fire.pop_front()));
            end else if (exp_fire.size() > 0 && exp_fire[0] <= cycle) begin
                void'(exp_fire.pop_front());
                checkOutput("fire_missed", 96'(fire), 96'(1));
            end
        end
    end

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            flush   = 1'b0;
            now_ts  = now_ts + 96'(step);
            tsi     = now_ts[95:64];
            tsf     = now_ts[63:0];
        end
    endtask

    task automatic set_time(input logic [95:0] t);
        now_ts = t;
        tsi    = t[95:64];
        tsf    = t[63:0];
    endtask

    task automatic push_entry(input logic [95:0] t);
        s_valid = 1'b1;
        s_tsi   = t[95:64];
        s_tsf   = t[63:0];
        applyStimulus(1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        applyStimulus(1);
    endtask

    initial begin
        int off;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_tsi     = '0;
        s_tsf     = '0;
        enable    = 1'b0;
        late_drop = 1'b0;
        flush     = 1'b0;
        pulse_len = 8'd4;
        step      = 1;
        set_time({32'd5, 64'd0});
        applyStimulus(3);
        rst = 1'b0;
        applyStimulus(2);

        $display("[TB] single entry");
        enable = 1'b1;
        set_time({32'd5, 64'd90});
        push_entry({32'd5, 64'd100});
        applyStimulus(20);

        $display("[TB] late entries");
        do_flush();
        step = 0;
        set_time({32'd10, 64'd0});
        push_entry({32'd9, 64'd0});
        applyStimulus(8);
        late_drop = 1'b1;
        for (int i = 0; i < 3; i++) push_entry({32'd9, 64'(i)});
        applyStimulus(8);

        $display("[TB] full queue");
        do_flush();
        enable    = 1'b0;
        late_drop = 1'b0;
        pulse_len = 8'd2;
        set_time({32'd20, 64'd0});
        for (int i = 0; i < DEPTH; i++) push_entry({32'd20, 64'(100 + 10 * i)});
        step   = 1;
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'b1;
            s_tsi   = 32'd20;
            s_tsf   = 64'd200;
            applyStimulus(1);
            if (m_push_acc) break;
        end
        applyStimulus(150);

        $display("[TB] flush mid-pulse");
        do_flush();
        pulse_len = 8'd10;
        set_time({32'd30, 64'd0});
        push_entry({32'd30, 64'd5});
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            if (m_st == M_PULSE && m_left == 8) begin
                flush   = 1'b1;
                s_valid = 1'b1;
                s_tsi   = 32'd30;
                s_tsf   = 64'd100;
                applyStimulus(1);
                break;
            end
        end
        applyStimulus(5);

        $display("[TB] enable gating");
        do_flush();
        enable    = 1'b0;
        pulse_len = 8'd3;
        set_time({32'd40, 64'd0});
        push_entry({32'd40, 64'd5});
        push_entry({32'd40, 64'd8});
        applyStimulus(20);
        enable = 1'b1;
        applyStimulus(20);

        $display("[TB] late counter saturation");
        do_flush();
        enable    = 1'b0;
        late_drop = 1'b1;
        set_time({32'd50, 64'd1000});
        for (int i = 0; i < 10; i++) push_entry({32'd50, 64'(i)});
        enable = 1'b1;
        applyStimulus(12);
        for (int i = 0; i < 4; i++) push_entry({32'd50, 64'(20 + i)});
        applyStimulus(8);

        $display("[TB] random traffic across a tsf carry");
        do_flush();
        set_time({32'd7, 64'hFFFF_FFFF_FFFF_FF00});
        enable    = 1'b1;
        late_drop = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step = int'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) enable = !enable;
            if ($urandom_range(0, 79) == 0) late_drop = !late_drop;
            if ($urandom_range(0, 29) == 0) pulse_len = 8'($urandom_range(0, 5));
            flush   = ($urandom_range(0, 99) == 0);
            s_valid = ($urandom_range(0, 99) < 35);
            off     = int'($urandom_range(0, 110)) - 30;
            {s_tsi, s_tsf} = now_ts + {{64{off[31]}}, 32'(off)};
            applyStimulus(1);
        end

        $display("[TB] reset mid-pulse");
        do_flush();
        enable    = 1'b1;
        late_drop = 1'b0;
        pulse_len = 8'd8;
        step      = 1;
        set_time({32'd60, 64'd0});
        push_entry({32'd60, 64'd4});
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1);
            if (m_st == M_PULSE && m_left == 5) begin
                rst = 1'b1;
                applyStimulus(2);
                rst = 1'b0;
                break;
            end
        end
        applyStimulus(5);

        do_flush();
        applyStimulus(3);
        checkOutput("fire_pending", 96'(exp_fire.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
